// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the I/Q FIR MAC scheduler.
// Also holds the overrun counter helper used when FIR_SCHED_OVF_CNT_EN is defined.
package fir_sched_pkg;
  localparam int W_DIN = 16;
  localparam int W_RES = 32;
  localparam logic CH_I = 1'b0;
  localparam logic CH_Q = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} sched_state_e;

  // Saturating overrun count. A clear and an increment in the same cycle
  // leave a count of one, so the new event is not lost.
  function automatic logic [15:0] ovf_cnt_next(input logic [15:0] c, input logic inc,
                                               input logic clr);
    if (clr) return {15'd0, inc};
    if (inc && (c != 16'hFFFF)) return c + 16'd1;
    return c;
  endfunction
endpackage

// File: rtl/fir_sched_chan_front.sv
// Per-channel front end: decimation phase counter, trigger sample buffer,
// pending flag and overrun detection for one of the I/Q channels.
module fir_sched_chan_front
  import fir_sched_pkg::*;
#(
  parameter int R = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_DIN-1:0] din_i,
  input  logic             din_val_i,
  input  logic             clr_i,
  output logic             pend_o,
  output logic [W_DIN-1:0] buf_o,
  output logic             ovf_evt_o
);
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(R - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [W_DIN-1:0] buf_q, buf_d;
  logic             trig;

  // A trigger coinciding with the issue clear re-arms pend and is not an overrun.
  always_comb begin
    trig   = din_val_i && (cnt_q == CNT_MAX);
    cnt_d  = cnt_q;
    if (din_val_i) cnt_d = trig ? '0 : cnt_q + 1'b1;
    buf_d     = trig ? din_i : buf_q;
    pend_d    = trig | (pend_q & ~clr_i);
    ovf_evt_o = trig & pend_q & ~clr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      buf_q  <= buf_d;
    end
  end

  assign pend_o = pend_q;
  assign buf_o  = buf_q;
endmodule

// File: rtl/fir_iq_mac_sched.sv
// Round-robin scheduler sharing one FIR MAC engine between I and Q channels.
// Define FIR_SCHED_OVF_CNT_EN to add saturating per-channel overrun counters.
module fir_iq_mac_sched
  import fir_sched_pkg::*;
#(
  parameter int R          = 2,
  parameter int TMO_CYCLES = 63
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_DIN-1:0] din_i,
  input  logic             din_i_val,
  input  logic [W_DIN-1:0] din_q,
  input  logic             din_q_val,
  output logic             eng_start,
  output logic             eng_ch,
  output logic [W_DIN-1:0] eng_din,
  input  logic             eng_done,
  input  logic [W_RES-1:0] eng_result,
  output logic [W_RES-1:0] dout_i,
  output logic             dout_i_val,
  output logic [W_RES-1:0] dout_q,
  output logic             dout_q_val,
  input  logic             clr_err,
  output logic             ovf_i,
  output logic             ovf_q,
  output logic             tmo
`ifdef FIR_SCHED_OVF_CNT_EN
  ,
  output logic [15:0]      ovf_cnt_i,
  output logic [15:0]      ovf_cnt_q
`endif
);
  localparam int WDW = $clog2(TMO_CYCLES + 1);
  localparam logic [WDW-1:0] TMO_MAX = WDW'(TMO_CYCLES - 1);

  sched_state_e     state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [W_DIN-1:0] eng_din_q, eng_din_d;
  logic [W_RES-1:0] dout_i_q, dout_i_d, dout_q_q, dout_q_d;
  logic             dout_i_val_q, dout_i_val_d, dout_q_val_q, dout_q_val_d;
  logic             ovf_i_q, ovf_q_q, tmo_q, tmo_set;

  logic             ich_pend, qch_pend, ich_ovf, qch_ovf, ich_clr, qch_clr;
  logic [W_DIN-1:0] ich_buf, qch_buf, sel_buf;

  assign ich_clr = (state_q == ISSUE) && (grant_q == CH_I);
  assign qch_clr = (state_q == ISSUE) && (grant_q == CH_Q);
  assign sel_buf = (grant_q == CH_Q) ? qch_buf : ich_buf;

  fir_sched_chan_front #(.R(R)) u_front_i (
    .clk(clk), .rst_n(rst_n), .din_i(din_i), .din_val_i(din_i_val), .clr_i(ich_clr),
    .pend_o(ich_pend), .buf_o(ich_buf), .ovf_evt_o(ich_ovf)
  );

  fir_sched_chan_front #(.R(R)) u_front_q (
    .clk(clk), .rst_n(rst_n), .din_i(din_q), .din_val_i(din_q_val), .clr_i(qch_clr),
    .pend_o(qch_pend), .buf_o(qch_buf), .ovf_evt_o(qch_ovf)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    eng_din_d    = eng_din_q;
    dout_i_d     = dout_i_q;
    dout_q_d     = dout_q_q;
    dout_i_val_d = 1'b0;
    dout_q_val_d = 1'b0;
    tmo_set      = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_set = eng_done;
        if (ich_pend || qch_pend) begin
          if (ich_pend && qch_pend) grant_d = ~last_grant_q;
          else                      grant_d = qch_pend ? CH_Q : CH_I;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_set   = eng_done;
        eng_din_d = sel_buf;
        wdog_d    = WDW'(1);
        state_d   = WAIT;
      end
      WAIT: begin
        // A completion in the final watchdog cycle is still accepted.
        if (eng_done) begin
          if (grant_q == CH_I) begin
            dout_i_d     = eng_result;
            dout_i_val_d = 1'b1;
          end else begin
            dout_q_d     = eng_result;
            dout_q_val_d = 1'b1;
          end
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (wdog_q == TMO_MAX) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= CH_I;
      last_grant_q <= CH_Q;
      wdog_q       <= '0;
      eng_din_q    <= '0;
      dout_i_q     <= '0;
      dout_q_q     <= '0;
      dout_i_val_q <= 1'b0;
      dout_q_val_q <= 1'b0;
      ovf_i_q      <= 1'b0;
      ovf_q_q      <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      eng_din_q    <= eng_din_d;
      dout_i_q     <= dout_i_d;
      dout_q_q     <= dout_q_d;
      dout_i_val_q <= dout_i_val_d;
      dout_q_val_q <= dout_q_val_d;
      ovf_i_q      <= ich_ovf | (ovf_i_q & ~clr_err);
      ovf_q_q      <= qch_ovf | (ovf_q_q & ~clr_err);
      tmo_q        <= tmo_set | (tmo_q & ~clr_err);
    end
  end

  assign eng_start  = (state_q == ISSUE);
  assign eng_ch     = grant_q;
  assign eng_din    = (state_q == ISSUE) ? sel_buf : eng_din_q;
  assign dout_i     = dout_i_q;
  assign dout_q     = dout_q_q;
  assign dout_i_val = dout_i_val_q;
  assign dout_q_val = dout_q_val_q;
  assign ovf_i      = ovf_i_q;
  assign ovf_q      = ovf_q_q;
  assign tmo        = tmo_q;

`ifdef FIR_SCHED_OVF_CNT_EN
  logic [15:0] ovf_cnt_i_q, ovf_cnt_q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_i_q <= '0;
      ovf_cnt_q_q <= '0;
    end else begin
      ovf_cnt_i_q <= ovf_cnt_next(ovf_cnt_i_q, ich_ovf, clr_err);
      ovf_cnt_q_q <= ovf_cnt_next(ovf_cnt_q_q, qch_ovf, clr_err);
    end
  end

  assign ovf_cnt_i = ovf_cnt_i_q;
  assign ovf_cnt_q = ovf_cnt_q_q;
`endif
endmodule

// File: tb/tb_fir_iq_mac_sched.sv
// Bench for fir_iq_mac_sched: directed R=2 table and corner sequences,
// plus a randomized R=1 run against a queue-based golden model.
module tb_fir_iq_mac_sched;
  localparam int TMO = 63;
  localparam int NJ  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // R=2 instance
  logic [15:0] din_i, din_q, eng_din;
  logic        din_i_val, din_q_val, eng_start, eng_ch, eng_done, clr_err;
  logic [31:0] eng_result, dout_i, dout_q;
  logic        dout_i_val, dout_q_val, ovf_i, ovf_q, tmo;
  // R=1 instance
  logic [15:0] b_din_i, b_din_q, b_eng_din;
  logic        b_din_i_val, b_din_q_val, b_eng_start, b_eng_ch, b_eng_done, b_clr_err;
  logic [31:0] b_eng_result, b_dout_i, b_dout_q;
  logic        b_dout_i_val, b_dout_q_val, b_ovf_i, b_ovf_q, b_tmo;
`ifdef FIR_SCHED_OVF_CNT_EN
  logic [15:0] ovf_cnt_i, ovf_cnt_q, b_ovf_cnt_i, b_ovf_cnt_q;
`endif

  fir_iq_mac_sched #(.R(2), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .din_i(din_i), .din_i_val(din_i_val), .din_q(din_q),
    .din_q_val(din_q_val), .eng_start(eng_start), .eng_ch(eng_ch), .eng_din(eng_din),
    .eng_done(eng_done), .eng_result(eng_result), .dout_i(dout_i), .dout_i_val(dout_i_val),
    .dout_q(dout_q), .dout_q_val(dout_q_val), .clr_err(clr_err), .ovf_i(ovf_i),
    .ovf_q(ovf_q), .tmo(tmo)
`ifdef FIR_SCHED_OVF_CNT_EN
    , .ovf_cnt_i(ovf_cnt_i), .ovf_cnt_q(ovf_cnt_q)
`endif
  );

  fir_iq_mac_sched #(.R(1), .TMO_CYCLES(TMO)) dut1 (
    .clk(clk), .rst_n(rst_n), .din_i(b_din_i), .din_i_val(b_din_i_val), .din_q(b_din_q),
    .din_q_val(b_din_q_val), .eng_start(b_eng_start), .eng_ch(b_eng_ch), .eng_din(b_eng_din),
    .eng_done(b_eng_done), .eng_result(b_eng_result), .dout_i(b_dout_i),
    .dout_i_val(b_dout_i_val), .dout_q(b_dout_q), .dout_q_val(b_dout_q_val),
    .clr_err(b_clr_err), .ovf_i(b_ovf_i), .ovf_q(b_ovf_q), .tmo(b_tmo)
`ifdef FIR_SCHED_OVF_CNT_EN
    , .ovf_cnt_i(b_ovf_cnt_i), .ovf_cnt_q(b_ovf_cnt_q)
`endif
  );

  typedef struct {
    logic        ch;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [31:0] res;
    logic [15:0] exp_din;
    logic [31:0] exp_dout;
  } vec_t;
  vec_t tbl[4];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_q_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    din_i = '0; din_q = '0; din_i_val = 0; din_q_val = 0;
    eng_done = 0; eng_result = '0; clr_err = 0;
    b_din_i = '0; b_din_q = '0; b_din_i_val = 0; b_din_q_val = 0;
    b_eng_done = 0; b_eng_result = '0; b_clr_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic ch, input logic [15:0] s);
    if (!ch) begin din_i = s; din_i_val = 1; end
    else     begin din_q = s; din_q_val = 1; end
    tick();
    din_i_val = 0; din_q_val = 0;
  endtask

  task automatic send2(input logic [15:0] si, input logic [15:0] sq);
    din_i = si; din_q = sq; din_i_val = 1; din_q_val = 1;
    tick();
    din_i_val = 0; din_q_val = 0;
  endtask

  // Returns in the cycle eng_start is high; exp_lat counts clocks from the call.
  task automatic wait_start(input string name, input int exp_lat, input logic exp_ch,
                            input logic [15:0] exp_din);
    int n = 0;
    while (!eng_start && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_ch"}, eng_ch, exp_ch);
    chk({name, "_din"}, eng_din, exp_din);
  endtask

  // Drives one eng_done; returns in the cycle after the done edge.
  task automatic finish_job(input string name, input logic ch, input logic [31:0] res);
    eng_done = 1; eng_result = res;
    tick();
    eng_done = 0; eng_result = '0;
    chk({name, "_val"}, ch ? dout_q_val : dout_i_val, 1);
    chk({name, "_oval"}, ch ? dout_i_val : dout_q_val, 0);
    chk({name, "_dout"}, ch ? dout_q : dout_i, res);
  endtask

  function automatic logic [31:0] eng_model(input logic ch, input logic [15:0] d);
    return {d ^ (ch ? 16'hC0DE : 16'h1234), ~d};
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{ch:1'b0, s0:16'h0100, s1:16'h0200, res:32'h12345678, exp_din:16'h0200, exp_dout:32'h12345678};
    tbl[1] = '{ch:1'b1, s0:16'h8000, s1:16'h7FFF, res:32'hDEADBEEF, exp_din:16'h7FFF, exp_dout:32'hDEADBEEF};
    tbl[2] = '{ch:1'b0, s0:16'hFFFF, s1:16'h0001, res:32'h80000000, exp_din:16'h0001, exp_dout:32'h80000000};
    tbl[3] = '{ch:1'b1, s0:16'h1234, s1:16'h0000, res:32'h00000001, exp_din:16'h0000, exp_dout:32'h00000001};

    do_reset();
    chk("rst_ctrl", {25'd0, ovf_i, ovf_q, tmo, dout_i_val, dout_q_val, eng_start, eng_ch}, 0);
    chk("rst_eng_din", eng_din, 0);
    chk("rst_dout_i", dout_i, 0);
    chk("rst_dout_q", dout_q, 0);

    // Single jobs, one per table row
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].ch, tbl[i].s0);
      chk("tbl_no_early_start", eng_start, 0);
      send(tbl[i].ch, tbl[i].s1);
      wait_start("tbl_start", 1, tbl[i].ch, tbl[i].exp_din);
      tick();
      chk("tbl_one_pulse", eng_start, 0);
      repeat (3) tick();
      chk("tbl_din_held", eng_din, tbl[i].exp_din);
      finish_job("tbl", tbl[i].ch, tbl[i].res);
      chk("tbl_dout_hold_val", tbl[i].ch ? dout_q : dout_i, tbl[i].exp_dout);
      tick();
      chk("tbl_val_once", {dout_i_val, dout_q_val}, 0);
      chk("tbl_flags", {ovf_i, ovf_q, tmo}, 0);
    end

    // Simultaneous triggers, then round-robin alternation
    do_reset();
    send2(16'h1111, 16'h2222);
    send2(16'h3333, 16'h4444);
    wait_start("t2_first_i", 1, 1'b0, 16'h3333);
    tick();
    send(1'b0, 16'h5555);
    send(1'b0, 16'h6666);
    finish_job("t2_i", 1'b0, 32'hAAAA0001);
    wait_start("t2_q_gap", 1, 1'b1, 16'h4444);
    tick();
    finish_job("t2_q", 1'b1, 32'hBBBB0002);
    wait_start("t2_i_again", 1, 1'b0, 16'h6666);
    tick();
    finish_job("t2_i2", 1'b0, 32'hCCCC0003);
    chk("t2_no_ovf", {ovf_i, ovf_q}, 0);

    // Trigger in the issue cycle, then a true overrun
    do_reset();
    send(1'b0, 16'hA001);
    send(1'b0, 16'hA002);
    send(1'b0, 16'hA003);
    chk("t3_issue", eng_start, 1);
    chk("t3_issue_din", eng_din, 16'hA002);
    send(1'b0, 16'hA004);
    chk("t3_same_cycle_no_ovf", ovf_i, 0);
    finish_job("t3a", 1'b0, 32'h0000A002);
    wait_start("t3_reissue", 1, 1'b0, 16'hA004);
    tick();
    send(1'b0, 16'hB001);
    send(1'b0, 16'hB002);
    chk("t3_pend_no_ovf", ovf_i, 0);
    send(1'b0, 16'hC001);
    send(1'b0, 16'hC002);
    chk("t3_ovf_i", ovf_i, 1);
    chk("t3_ovf_q", ovf_q, 0);
`ifdef FIR_SCHED_OVF_CNT_EN
    chk("t3_cnt_i", ovf_cnt_i, 1);
    chk("t3_cnt_q", ovf_cnt_q, 0);
`endif
    finish_job("t3b", 1'b0, 32'h0000A004);
    wait_start("t3_newest", 1, 1'b0, 16'hC002);
    tick();
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("t3_clr_ovf", ovf_i, 0);
`ifdef FIR_SCHED_OVF_CNT_EN
    chk("t3_clr_cnt", ovf_cnt_i, 0);
`endif
    finish_job("t3c", 1'b0, 32'h0000C002);

    // Engine never answers
    do_reset();
    send2(16'h4001, 16'h5001);
    send2(16'h4002, 16'h5002);
    wait_start("t4_start", 1, 1'b0, 16'h4002);
    begin
      int n = 0;
      while (!tmo && n < 200) begin
        tick();
        n++;
      end
      chk("t4_tmo_lat", n, TMO);
    end
    chk("t4_idle", eng_start, 0);
    chk("t4_no_dout", {dout_i_val, dout_q_val}, 0);
    wait_start("t4_next", 1, 1'b1, 16'h5002);
    tick();
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("t4_clr_tmo", tmo, 0);
    finish_job("t4_q", 1'b1, 32'h55550002);

    // Reset during WAIT, late eng_done afterwards
    do_reset();
    send(1'b0, 16'h7001);
    send(1'b0, 16'h7002);
    wait_start("t5_a", 1, 1'b0, 16'h7002);
    tick();
    finish_job("t5_a", 1'b0, 32'h77778888);
    send(1'b0, 16'h7003);
    send(1'b0, 16'h7004);
    wait_start("t5_b", 1, 1'b0, 16'h7004);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    chk("t5_rst_dout", dout_i, 0);
    chk("t5_rst_din", eng_din, 0);
    chk("t5_rst_ctrl", {eng_start, eng_ch, dout_i_val, ovf_i, tmo}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    eng_done = 1; eng_result = 32'h99999999; clr_err = 1;
    tick();
    eng_done = 0; eng_result = '0; clr_err = 0;
    chk("t5_late_no_val", dout_i_val, 0);
    chk("t5_late_dout", dout_i, 0);
    chk("t5_late_tmo", tmo, 1);

    // Randomized R=1 traffic with a 33-clock engine
    do_reset();
    begin
      int jobs = 0, got_i = 0, got_q = 0, eng_cnt = 0;
      logic e_ch = 0;
      logic [15:0] e_din = '0;
      logic [15:0] s;
      for (int cyc = 0; cyc < NJ * 40 + 100; cyc++) begin
        b_din_i_val = 0; b_din_q_val = 0; b_eng_done = 0;
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            b_eng_done = 1;
            b_eng_result = eng_model(e_ch, e_din);
          end
        end
        if ((cyc % 40 == 0) && (jobs < NJ)) begin
          s = 16'($urandom_range(0, 65535));
          if (jobs % 2 == 0) begin
            b_din_i = s; b_din_i_val = 1; exp_i_q.push_back(eng_model(1'b0, s));
          end else begin
            b_din_q = s; b_din_q_val = 1; exp_q_q.push_back(eng_model(1'b1, s));
          end
          jobs++;
        end
        tick();
        if (b_eng_start) begin
          chk("t6_engine_free", eng_cnt, 0);
          e_ch = b_eng_ch; e_din = b_eng_din; eng_cnt = 33;
        end
        if (b_dout_i_val) begin
          got_i++;
          if (exp_i_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL t6_dout_i: got %h expected no result", b_dout_i);
          end else chk("t6_dout_i", b_dout_i, exp_i_q.pop_front());
        end
        if (b_dout_q_val) begin
          got_q++;
          if (exp_q_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL t6_dout_q: got %h expected no result", b_dout_q);
          end else chk("t6_dout_q", b_dout_q, exp_q_q.pop_front());
        end
      end
      chk("t6_count_i", got_i, NJ / 2);
      chk("t6_count_q", got_q, NJ / 2);
      chk("t6_left", exp_i_q.size() + exp_q_q.size(), 0);
      chk("t6_flags", {b_ovf_i, b_ovf_q, b_tmo}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
